button_select_stepper: RTL and testbench

//  Upstream stage of the 16:1 switch mux; produces its 4-bit select word from the four board buttons.

---
 rtl/button_select_stepper_pkg.sv | 23 ++
 rtl/button_select_stepper_btn_debounce_edge.sv | 154 +++++++++++++++
 rtl/button_select_stepper.sv | 84 ++++++++
 tb/tb_button_select_stepper.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/button_select_stepper_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : button_select_stepper_pkg
//  Brief    : Shared debounce FSM state encoding and select-range helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package button_select_stepper_pkg;

    localparam int unsigned SEL_WIDTH_DEFAULT = 4;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    function automatic int unsigned sel_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    localparam int unsigned SEL_MAX = sel_max(SEL_WIDTH_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/button_select_stepper_btn_debounce_edge.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce_edge
//  Brief    : Synchroniser + debounce FSM for one raw button; emits one press
//             pulse per accepted press. Auto-repeat timer under AUTOREPEAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_edge
    import button_select_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 20000000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic o_press_pulse,
    output logic o_held_level
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync0;
    logic               r_sync1;
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_press_pulse;

    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_cnt_done;
    logic               w_accept;
    logic               w_rep_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= i_btn_raw;
            r_sync1 <= r_sync0;
        end
    end

    // The entry sample counts as the first stable cycle, so the wait states
    // leave once the incremented count reaches DEBOUNCE_CYCLES-1.
    assign w_cnt_inc  = r_cnt + c_CNT_W'(1);
    assign w_cnt_done = (w_cnt_inc == c_CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync1) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!r_sync1) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_done) begin
                    w_state_nxt = ST_HELD;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            ST_HELD: begin
                if (!r_sync1) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (r_sync1) begin
                    w_state_nxt = ST_HELD;
                end else if (w_cnt_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_press_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_press_pulse <= w_accept | w_rep_fire;
        end
    end

`ifdef AUTOREPEAT_EN
    if (REPEAT_EN) begin : g_repeat
        localparam int c_REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
        localparam int c_REP_W   = $clog2(c_REP_MAX + 1);
        localparam logic [c_REP_W-1:0] c_HOLD_LAST = c_REP_W'(HOLD_CYCLES - 1);
        localparam logic [c_REP_W-1:0] c_REP_LAST  = c_REP_W'(REPEAT_CYCLES - 1);

        logic [c_REP_W-1:0] r_rep_cnt;
        logic               r_rep_armed;
        logic               w_in_hold;
        logic               w_rep_hit;

        assign w_in_hold = (r_state == ST_HELD) && r_sync1;
        assign w_rep_hit = r_rep_armed ? (r_rep_cnt == c_REP_LAST) : (r_rep_cnt == c_HOLD_LAST);
        assign w_rep_fire = w_in_hold && w_rep_hit;

        // First interval is the long hold delay, every later one the repeat period.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b0;
            end else if (!w_in_hold) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b0;
            end else if (w_rep_hit) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b1;
            end else begin
                r_rep_cnt   <= r_rep_cnt + c_REP_W'(1);
            end
        end
    end else begin : g_no_repeat
        assign w_rep_fire = 1'b0;
    end
`else
    if (REPEAT_EN && (HOLD_CYCLES > 0) && (REPEAT_CYCLES > 0)) begin : g_repeat_off
        assign w_rep_fire = 1'b0;
    end else begin : g_no_repeat
        assign w_rep_fire = 1'b0;
    end
`endif

    assign o_press_pulse = r_press_pulse;
    assign o_held_level  = (r_state == ST_HELD) || (r_state == ST_RELEASE_WAIT);

endmodule
`default_nettype wire

// File: rtl/button_select_stepper.sv
`default_nettype none
// ============================================================================
//  Module   : button_select_stepper
//  Brief    : Four debounced buttons step a wrapping select word for the 16:1
//             switch mux. Optional hold-to-repeat on up/down: AUTOREPEAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module button_select_stepper
    import button_select_stepper_pkg::*;
#(
    parameter int SEL_WIDTH       = SEL_WIDTH_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 20000000
) (
    input  logic                 clockLineFromBoard,
    input  logic                 resetWholeSystem,
    input  logic                 upBtn,
    input  logic                 downBtn,
    input  logic                 leftBtn,
    input  logic                 rightBtn,
    output logic [SEL_WIDTH-1:0] selectorBitsFromButtons,
    output logic                 selChangePulse
);

    localparam int c_IDX_UP    = 0;
    localparam int c_IDX_DOWN  = 1;
    localparam int c_IDX_LEFT  = 2;
    localparam int c_IDX_RIGHT = 3;
    localparam logic [SEL_WIDTH-1:0] c_SEL_MAX = SEL_WIDTH'(sel_max(SEL_WIDTH));

    logic [3:0]           w_raw;
    logic [3:0]           w_press;
    logic [3:0]           w_held;
    logic [SEL_WIDTH-1:0] w_sel_nxt;
    logic [SEL_WIDTH-1:0] r_sel;
    logic                 r_chg;

    assign w_raw = {rightBtn, leftBtn, downBtn, upBtn};

    // Only up and down (indices 0 and 1) are allowed to auto-repeat.
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        btn_debounce_edge #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (gi < 2)
        ) u_btn (
            .clk           (clockLineFromBoard),
            .rst           (resetWholeSystem),
            .i_btn_raw     (w_raw[gi]),
            .o_press_pulse (w_press[gi]),
            .o_held_level  (w_held[gi])
        );
    end

    always_comb begin
        w_sel_nxt = r_sel;
        if (w_press[c_IDX_LEFT]) begin
            w_sel_nxt = '0;
        end else if (w_press[c_IDX_RIGHT]) begin
            w_sel_nxt = c_SEL_MAX;
        end else if (w_press[c_IDX_UP] && !w_press[c_IDX_DOWN]) begin
            w_sel_nxt = r_sel + SEL_WIDTH'(1);
        end else if (w_press[c_IDX_DOWN] && !w_press[c_IDX_UP]) begin
            w_sel_nxt = r_sel - SEL_WIDTH'(1);
        end
    end

    always_ff @(posedge clockLineFromBoard or posedge resetWholeSystem) begin
        if (resetWholeSystem) begin
            r_sel <= '0;
            r_chg <= 1'b0;
        end else begin
            r_sel <= w_sel_nxt;
            r_chg <= (w_sel_nxt != r_sel);
        end
    end

    assign selectorBitsFromButtons = r_sel;
    assign selChangePulse          = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_button_select_stepper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_select_stepper
//  Brief    : Directed + randomized bench for button_select_stepper with a
//             press-level select model (DEBOUNCE=4, HOLD=20, REPEAT=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_select_stepper;

    localparam int c_DEB = 4;
    localparam int c_HOLD = 20;
    localparam int c_REP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [3:0] sel;
    logic       chg;

    int n_checks = 0;
    int n_errors = 0;
    int chg_seen = 0;
    int sel_model = 0;

    button_select_stepper #(
        .SEL_WIDTH       (4),
        .DEBOUNCE_CYCLES (c_DEB),
        .HOLD_CYCLES     (c_HOLD),
        .REPEAT_CYCLES   (c_REP)
    ) dut (
        .clockLineFromBoard      (clk),
        .resetWholeSystem        (rst),
        .upBtn                   (up),
        .downBtn                 (down),
        .leftBtn                 (left),
        .rightBtn                (right),
        .selectorBitsFromButtons (sel),
        .selChangePulse          (chg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (chg === 1'b1) chg_seen++;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] mask);
        {right, left, down, up} = mask;
    endtask

    // Select rule applied to one accepted press of the buttons in mask.
    function automatic int apply(input int s, input logic [3:0] mask);
        if (mask[2]) return 0;
        if (mask[3]) return 15;
        if (mask[0] && !mask[1]) return (s + 1) % 16;
        if (mask[1] && !mask[0]) return (s + 15) % 16;
        return s;
    endfunction

    function automatic int steps_for_hold(input int hold);
        int n;
        n = 1;
`ifdef AUTOREPEAT_EN
        if (hold - 4 >= c_HOLD) n = n + 1 + (hold - 4 - c_HOLD) / c_REP;
`endif
        return n;
    endfunction

    task automatic press(input logic [3:0] mask, input int hold, input bit bounce, input bit rel_bounce);
        if (bounce) begin
            repeat ($urandom_range(1, 2)) begin
                drive(mask);   ticks($urandom_range(1, 3));
                drive(4'b0);   ticks($urandom_range(1, 3));
            end
        end
        drive(mask);
        ticks(hold);
        if (rel_bounce) begin
            drive(4'b0);  ticks($urandom_range(1, 2));
            drive(mask);  ticks($urandom_range(1, 2));
        end
        drive(4'b0);
        ticks(10);
    endtask

    task automatic op(input string tag, input logic [3:0] mask, input bit bounce, input bit rel_bounce);
        int exp_sel;
        int c0;
        exp_sel = apply(sel_model, mask);
        c0 = chg_seen;
        press(mask, $urandom_range(6, 12), bounce, rel_bounce);
        check({tag, "_sel"}, int'(sel), exp_sel);
        check({tag, "_chg"}, chg_seen - c0, (exp_sel != sel_model) ? 1 : 0);
        sel_model = exp_sel;
    endtask

    initial begin
        logic [3:0] m;
        int c0;
        int exp_sel;

        // Reset state, then a press interrupted by reset.
        ticks(2);
        check("rst_sel", int'(sel), 0);
        check("rst_chg", int'(chg), 0);
        rst = 1'b0;
        drive(4'b0001);
        ticks(3);
        rst = 1'b1;
        ticks(2);
        check("midrst_sel", int'(sel), 0);
        rst = 1'b0;
        c0 = chg_seen;
        ticks(1);
        check("postrst_sel", int'(sel), 0);
        check("postrst_chg", int'(chg), 0);
        ticks(5);
        check("fresh_early_sel", int'(sel), 0);
        check("fresh_early_chg", chg_seen - c0, 0);
        ticks(1);
        check("fresh_step_sel", int'(sel), 1);
        check("fresh_step_chg", int'(chg), 1);
        ticks(1);
        check("chg_one_cycle", int'(chg), 0);
        drive(4'b0);
        ticks(10);
        sel_model = 1;

        // Bounce 1-0-1-0 at 2-cycle spacing, then a stable 10-cycle hold.
        c0 = chg_seen;
        repeat (2) begin
            drive(4'b0001); ticks(2);
            drive(4'b0000); ticks(2);
        end
        drive(4'b0001);
        ticks(6);
        check("bounce_before_sel", int'(sel), 1);
        ticks(1);
        check("bounce_land_sel", int'(sel), 2);
        ticks(3);
        drive(4'b0);
        ticks(10);
        check("bounce_chg", chg_seen - c0, 1);
        sel_model = 2;

        op("left0", 4'b0100, 1'b0, 1'b0);
        op("down_wrap", 4'b0010, 1'b0, 1'b0);
        op("left1", 4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) press(4'b0001, 6, 1'b0, 1'b0);
        check("up15_sel", int'(sel), 15);
        sel_model = 15;
        op("up_wrap", 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) press(4'b0001, 6, 1'b0, 1'b0);
        sel_model = 7;
        op("updown_cancel", 4'b0011, 1'b0, 1'b0);
        op("up8", 4'b0001, 1'b1, 1'b0);
        op("up9", 4'b0001, 1'b0, 1'b0);
        op("left_up", 4'b0101, 1'b0, 1'b0);
        op("right_max", 4'b1000, 1'b0, 1'b0);
        op("right_at_max", 4'b1000, 1'b0, 1'b0);
        op("left_relbounce", 4'b0100, 1'b0, 1'b1);
        op("left_at_zero", 4'b0100, 1'b0, 1'b0);

        // Long hold of up from 0.
        c0 = chg_seen;
        exp_sel = (sel_model + steps_for_hold(60)) % 16;
        press(4'b0001, 60, 1'b0, 1'b0);
        check("hold60_sel", int'(sel), exp_sel);
        check("hold60_chg", chg_seen - c0, steps_for_hold(60));
        sel_model = exp_sel;

        // Randomized presses with bounces.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    m = 4'b0001;
                2, 3:    m = 4'b0010;
                4:       m = 4'b0100;
                5:       m = 4'b1000;
                default: m = 4'($urandom_range(1, 15));
            endcase
            op("rand", m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
